// File: rtl/ddr2_v10_1_sequencer_mailbox_rfile.sv
// Avalon-MM register file and mailbox shared by the sequencer NIOS and the JTAG debug master.
// Zero-wait writes with byte enables, one-wait registered reads, RX/TX pending flags and a step counter.
module ddr2_v10_1_sequencer_mailbox_rfile #(
   parameter int AVL_DATA_WIDTH = 32,
   parameter int AVL_ADDR_WIDTH = 16,
   parameter int NUM_REGS       = 8,
   parameter int SEL_BITS       = 3
) (
   input  logic                        avl_clk,
   input  logic                        avl_reset_n,
   input  logic [AVL_ADDR_WIDTH-1:0]   avl_address,
   input  logic                        avl_write,
   input  logic [AVL_DATA_WIDTH-1:0]   avl_writedata,
   input  logic [AVL_DATA_WIDTH/8-1:0] avl_byteenable,
   input  logic                        avl_read,
   output logic [AVL_DATA_WIDTH-1:0]   avl_readdata,
   output logic                        avl_waitrequest,
   output logic                        rx_pending,
   output logic                        tx_pending,
   output logic [7:0]                  step_count
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int BE_W  = AVL_DATA_WIDTH / 8;

   localparam logic [IDX_W-1:0] IDX_RX     = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_STEP   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_TX     = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(5);
   localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(6);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RD_DATA = 1'b1
   } state_t;

   function automatic logic [AVL_DATA_WIDTH-1:0] merge_bytes(
      input logic [AVL_DATA_WIDTH-1:0] old_word,
      input logic [AVL_DATA_WIDTH-1:0] new_word,
      input logic [BE_W-1:0]           be
   );
      logic [AVL_DATA_WIDTH-1:0] res;
      for (int b = 0; b < BE_W; b++) begin
         res[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
      end
      return res;
   endfunction

   state_t                    state_r;
   state_t                    next_state_s;
   logic                      rd_load_s;
   logic [AVL_DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic [AVL_DATA_WIDTH-1:0] rd_data_s;
   logic [AVL_DATA_WIDTH-1:0] status_s;
   logic                      sel_s;
   logic [IDX_W-1:0]          idx_s;
   logic                      wr_s;
   logic                      any_be_s;
   logic                      ctrl_clr_rx_s;
   logic                      ctrl_clr_tx_s;
   logic                      unused_addr_s;

   // Address decode: only the selector field and the index bits matter.
   assign sel_s         = (avl_address[AVL_ADDR_WIDTH-1 -: SEL_BITS] == {SEL_BITS{1'b0}});
   assign idx_s         = avl_address[IDX_W-1:0];
   assign unused_addr_s = ^avl_address;
   assign wr_s          = avl_write & sel_s;
   assign any_be_s      = |avl_byteenable;
   assign ctrl_clr_rx_s = wr_s & (idx_s == IDX_CTRL) & avl_byteenable[0] & avl_writedata[0];
   assign ctrl_clr_tx_s = wr_s & (idx_s == IDX_CTRL) & avl_byteenable[0] & avl_writedata[1];

   // Read FSM state register.
   always_ff @(posedge avl_clk) begin
      if (!avl_reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Read FSM next state; a write alongside a read in IDLE wins and the read is ignored.
   always_comb begin
      next_state_s    = state_r;
      avl_waitrequest = 1'b0;
      rd_load_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (avl_read && !avl_write) begin
               avl_waitrequest = 1'b1;
               rd_load_s       = 1'b1;
               next_state_s    = ST_RD_DATA;
            end else begin
               next_state_s    = ST_IDLE;
            end
         end
         ST_RD_DATA: next_state_s = ST_IDLE;
         default:    next_state_s = ST_IDLE;
      endcase
   end

   // Read-data multiplexer, including the synthesized STATUS word.
   always_comb begin
      status_s       = '0;
      status_s[0]    = rx_pending;
      status_s[1]    = tx_pending;
      status_s[15:8] = step_count;
      rd_data_s      = '0;
      if (!sel_s) begin
         rd_data_s = '0;
      end else begin
         case (idx_s)
            IDX_STATUS: rd_data_s = status_s;
            IDX_CTRL:   rd_data_s = '0;
            default:    rd_data_s = regs_r[idx_s];
         endcase
      end
   end

   // Register array writes; STATUS and CTRL have no storage behind them.
   always_ff @(posedge avl_clk) begin
      if (!avl_reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wr_s && (idx_s != IDX_STATUS) && (idx_s != IDX_CTRL)) begin
         regs_r[idx_s] <= merge_bytes(regs_r[idx_s], avl_writedata, avl_byteenable);
      end
   end

   // Pending flags and step counter.
   always_ff @(posedge avl_clk) begin
      if (!avl_reset_n) begin
         rx_pending <= 1'b0;
         tx_pending <= 1'b0;
         step_count <= 8'd0;
      end else begin
         if (wr_s && any_be_s && (idx_s == IDX_RX)) begin
            rx_pending <= 1'b1;
         end else if (ctrl_clr_rx_s) begin
            rx_pending <= 1'b0;
         end
         if (wr_s && any_be_s && (idx_s == IDX_TX)) begin
            tx_pending <= 1'b1;
         end else if (ctrl_clr_tx_s) begin
            tx_pending <= 1'b0;
         end
         if (wr_s && any_be_s && (idx_s == IDX_STEP)) begin
            step_count <= step_count + 8'd1;
         end
      end
   end

   // Registered read data; holds until the next read is loaded.
   always_ff @(posedge avl_clk) begin
      if (!avl_reset_n) begin
         avl_readdata <= '0;
      end else if (rd_load_s) begin
         avl_readdata <= rd_data_s;
      end
   end

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_mailbox_rfile.sv
// Directed, table-driven bench for the sequencer mailbox register file.
module tb_ddr2_v10_1_sequencer_mailbox_rfile;

   logic        avl_clk;
   logic        avl_reset_n;
   logic [15:0] avl_address;
   logic        avl_write;
   logic [31:0] avl_writedata;
   logic [3:0]  avl_byteenable;
   logic        avl_read;
   logic [31:0] avl_readdata;
   logic        avl_waitrequest;
   logic        rx_pending;
   logic        tx_pending;
   logic [7:0]  step_count;

   int n_checks = 0;
   int n_errors = 0;

   ddr2_v10_1_sequencer_mailbox_rfile dut (
      .avl_clk         (avl_clk),
      .avl_reset_n     (avl_reset_n),
      .avl_address     (avl_address),
      .avl_write       (avl_write),
      .avl_writedata   (avl_writedata),
      .avl_byteenable  (avl_byteenable),
      .avl_read        (avl_read),
      .avl_readdata    (avl_readdata),
      .avl_waitrequest (avl_waitrequest),
      .rx_pending      (rx_pending),
      .tx_pending      (tx_pending),
      .step_count      (step_count)
   );

   initial begin
      avl_clk = 1'b0;
      forever #5 avl_clk = ~avl_clk;
   end

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_rx;
      logic        exp_tx;
      logic [7:0]  exp_step;
   } vec_t;

   vec_t vecs [32];
   int   n_vecs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
      @(negedge avl_clk);
      avl_address    = addr;
      avl_writedata  = data;
      avl_byteenable = be;
      avl_write      = 1'b1;
      @(posedge avl_clk);
      #1;
      avl_write      = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] addr, output logic [31:0] data, output int waits);
      @(negedge avl_clk);
      avl_address = addr;
      avl_read    = 1'b1;
      waits       = 0;
      #1;
      while (avl_waitrequest && waits < 8) begin
         @(posedge avl_clk);
         #1;
         waits++;
      end
      data = avl_readdata;
      @(posedge avl_clk);
      #1;
      avl_read = 1'b0;
   endtask

   task automatic add_vec(input logic is_wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] exp_rd,
                          input logic exp_rx, input logic exp_tx);
      vecs[n_vecs] = '{is_wr, addr, data, be, exp_rd, exp_rx, exp_tx, 8'd0};
      n_vecs++;
   endtask

   initial begin
      logic [31:0] rd;
      int          waits;

      avl_reset_n    = 1'b0;
      avl_address    = 16'h0000;
      avl_write      = 1'b0;
      avl_writedata  = 32'h0;
      avl_byteenable = 4'h0;
      avl_read       = 1'b0;
      n_vecs         = 0;

      // Write/read vectors; the table never touches INFO_STEP so step_count stays 0.
      add_vec(1'b1, 16'h0007, 32'hDEADBEEF, 4'b0101, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0007, 32'h0,        4'b0000, 32'h00AD00EF, 1'b0, 1'b0);
      add_vec(1'b1, 16'h0007, 32'hFFFFFFFF, 4'b1000, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0007, 32'h0,        4'b0000, 32'hFFAD00EF, 1'b0, 1'b0);
      add_vec(1'b1, 16'h0002, 32'h12345678, 4'b1111, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0002, 32'h0,        4'b0000, 32'h12345678, 1'b0, 1'b0);
      add_vec(1'b1, 16'h0003, 32'hA5A5A5A5, 4'b0011, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0003, 32'h0,        4'b0000, 32'h0000A5A5, 1'b0, 1'b0);
      add_vec(1'b1, 16'h0000, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b1, 1'b0);
      add_vec(1'b0, 16'h0005, 32'h0,        4'b0000, 32'h00000001, 1'b1, 1'b0);
      add_vec(1'b1, 16'h0004, 32'h00001234, 4'b1111, 32'h0,        1'b1, 1'b1);
      add_vec(1'b0, 16'h0005, 32'h0,        4'b0000, 32'h00000003, 1'b1, 1'b1);
      add_vec(1'b0, 16'h0004, 32'h0,        4'b0000, 32'h00001234, 1'b1, 1'b1);
      add_vec(1'b1, 16'h0006, 32'h00000002, 4'b0001, 32'h0,        1'b1, 1'b0);
      add_vec(1'b0, 16'h0005, 32'h0,        4'b0000, 32'h00000001, 1'b1, 1'b0);
      add_vec(1'b0, 16'h0006, 32'h0,        4'b0000, 32'h00000000, 1'b1, 1'b0);
      add_vec(1'b1, 16'h0006, 32'h00000101, 4'b0010, 32'h0,        1'b1, 1'b0);
      add_vec(1'b1, 16'h0006, 32'h00000001, 4'b0001, 32'h0,        1'b0, 1'b0);
      add_vec(1'b1, 16'h0005, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0005, 32'h0,        4'b0000, 32'h00000000, 1'b0, 1'b0);
      add_vec(1'b1, 16'h0000, 32'h11111111, 4'b0000, 32'h0,        1'b0, 1'b0);
      add_vec(1'b1, 16'h0017, 32'h11111111, 4'b1111, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0007, 32'h0,        4'b0000, 32'h11111111, 1'b0, 1'b0);
      add_vec(1'b1, 16'hE007, 32'h22222222, 4'b1111, 32'h0,        1'b0, 1'b0);
      add_vec(1'b1, 16'hE004, 32'h22222222, 4'b1111, 32'h0,        1'b0, 1'b0);
      add_vec(1'b0, 16'h0007, 32'h0,        4'b0000, 32'h11111111, 1'b0, 1'b0);
      add_vec(1'b0, 16'hE007, 32'h0,        4'b0000, 32'h00000000, 1'b0, 1'b0);
      add_vec(1'b0, 16'hE000, 32'h0,        4'b0000, 32'h00000000, 1'b0, 1'b0);

      repeat (3) @(posedge avl_clk);
      #1;
      avl_reset_n = 1'b1;
      chk("reset_readdata", avl_readdata, 32'h0);
      chk("reset_waitreq", {31'd0, avl_waitrequest}, 32'h0);
      chk("reset_flags", {30'd0, tx_pending, rx_pending}, 32'h0);
      chk("reset_step", {24'd0, step_count}, 32'h0);

      for (int i = 0; i < 8; i++) begin
         do_read(16'(i), rd, waits);
         chk($sformatf("reset_read_idx%0d", i), rd, 32'h0);
         chk($sformatf("reset_read_waits%0d", i), 32'(waits), 32'd1);
      end

      for (int i = 0; i < n_vecs; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
         end else begin
            do_read(vecs[i].addr, rd, waits);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'd1);
         end
         chk($sformatf("vec%0d_rx", i), {31'd0, rx_pending}, {31'd0, vecs[i].exp_rx});
         chk($sformatf("vec%0d_tx", i), {31'd0, tx_pending}, {31'd0, vecs[i].exp_tx});
         chk($sformatf("vec%0d_step", i), {24'd0, step_count}, {24'd0, vecs[i].exp_step});
      end

      // Step counter wrap: 257 enabled writes to INFO_STEP, plus one with no lanes enabled.
      for (int i = 0; i < 257; i++) begin
         do_write(16'h0001, 32'(i), 4'b1111);
      end
      do_write(16'h0001, 32'hFFFFFFFF, 4'b0000);
      chk("step_wrap", {24'd0, step_count}, 32'h1);
      do_read(16'h0005, rd, waits);
      chk("status_step", rd, 32'h00000100);
      do_read(16'h0001, rd, waits);
      chk("info_step_data", rd, 32'h00000100);

      // Simultaneous read and write in IDLE: write wins, no stall.
      @(negedge avl_clk);
      avl_address    = 16'h0003;
      avl_writedata  = 32'h5A5A0000;
      avl_byteenable = 4'b1100;
      avl_write      = 1'b1;
      avl_read       = 1'b1;
      #1;
      chk("rdwr_waitreq", {31'd0, avl_waitrequest}, 32'h0);
      @(posedge avl_clk);
      #1;
      avl_write = 1'b0;
      avl_read  = 1'b0;
      do_read(16'h0003, rd, waits);
      chk("rdwr_data", rd, 32'h5A5AA5A5);
      chk("rdwr_readdata_held", avl_readdata, 32'h5A5AA5A5);

      // Reset asserted while the FSM sits in RD_DATA.
      do_write(16'h0000, 32'h0000BEEF, 4'b1111);
      @(negedge avl_clk);
      avl_address = 16'h0007;
      avl_read    = 1'b1;
      @(posedge avl_clk);
      #1;
      chk("rd_data_state_rdata", avl_readdata, 32'h11111111);
      avl_reset_n = 1'b0;
      @(negedge avl_clk);
      avl_read = 1'b0;
      @(posedge avl_clk);
      #1;
      avl_reset_n = 1'b1;
      chk("midrd_reset_waitreq", {31'd0, avl_waitrequest}, 32'h0);
      chk("midrd_reset_rdata", avl_readdata, 32'h0);
      chk("midrd_reset_rx", {31'd0, rx_pending}, 32'h0);
      do_read(16'h0007, rd, waits);
      chk("post_reset_rdata", rd, 32'h0);
      chk("post_reset_waits", 32'(waits), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
